uart_tx: RTL
============

# uart_tx

Transmit side of the UART subsystem: takes parallel bytes through a valid/ready handshake and serialises each as one UART frame on a single line. A frame is start bit, DATA_WIDTH data bits LSB first, an optional parity bit and one stop bit. One bit is sent per clock, so the clock is the baud clock. The block pairs with the receive path and uses the same frame format and parity convention, so the two ends interoperate directly.

## Interface
- DATA_WIDTH, 8, number of data bits per frame (4..16)
- UART_TX_CLK  in  1  baud clock; one bit period per cycle
- UART_TX_RST  in  1  asynchronous, active-high reset
- UART_TX_P_DATA  in  DATA_WIDTH  byte to send; sampled on accept
- UART_TX_DATA_VALID  in  1  upstream offers P_DATA
- UART_TX_PAR_EN  in  1  1 = insert a parity bit; sampled on accept
- UART_TX_PAR_TYP  in  1  0 = even, 1 = odd; sampled on accept
- UART_TX_READY  out  1  holding register empty; an accept happens when VALID and READY are both high at a rising edge
- UART_TX_OUT  out  1  serial line; idles high; registered
- UART_TX_BUSY  out  1  high while a frame is on the line

## Operation
- Storage:
  - one-entry holding register (data, PAR_EN, PAR_TYP, hold_full)
  - DATA_WIDTH shift register
  - bit counter of width ceil(log2(DATA_WIDTH))
  - latched parity bit
- READY = ~hold_full & ~UART_TX_RST.
- On accept, set hold_full and capture P_DATA, PAR_EN and PAR_TYP.
- Parity is computed from the held data at load time:
  - even: XOR of the data bits
  - odd: inverted XOR of the data bits
- Changes to PAR_EN or PAR_TYP after accept have no effect on that frame.
- FSM states, Gray encoded:
  - IDLE = 000: line 1. If hold_full → START.
  - START = 001: line 0. → DATA.
  - DATA = 011: line = shift[0]; shift right each cycle; bit counter increments. At count DATA_WIDTH-1 → PARITY if the latched PAR_EN is set, else → STOP.
  - PARITY = 010: line = latched parity bit. → STOP.
  - STOP = 110: line 1. If hold_full → START, giving back-to-back frames with no idle gap; else → IDLE.
  - Unused encodings → IDLE, line 1.
- On each transition into START:
  - the shift register loads the held data
  - the parity bit and PAR_EN are latched from the held values
  - hold_full clears
  - the bit counter clears
- BUSY = 1 in every state except IDLE.
- Asserting reset mid-frame:
  - line returns to 1 immediately
  - FSM goes to IDLE
  - holding register is emptied; the pending byte is lost
  - no partial frame resumes after reset

## Timing
- Reset values: UART_TX_OUT = 1, UART_TX_BUSY = 0, UART_TX_READY = 0 while reset is high and 1 after it releases.
- Latency from idle: accept at edge E0 → OUT falls at E1, data bit i is on the line from E(2+i), parity (if enabled) follows the last data bit, then the stop bit.
- Frame length: DATA_WIDTH+2 cycles without parity, DATA_WIDTH+3 with parity (10 or 11 at the default width).
- READY falls at the accept edge and rises at the edge that enters START.
  - No accept can coincide with a load, because READY is low throughout that cycle.
- Throughput: a byte accepted anytime during frame N starts exactly one cycle after N's stop bit begins, i.e. its start bit immediately follows the single stop cycle.
- VALID held high while READY is low is not an accept. P_DATA may change freely in those cycles.
- OUT, BUSY and the state update only on clock edges, except for the asynchronous reset.

## Structure
- Shared package uart_pkg holds:
  - the Gray state encodings, shared with the receive controller
  - parity type constants PAR_EVEN = 0, PAR_ODD = 1
  - the default DATA_WIDTH
- Natural split: sub-module uart_tx_fsm contains the state register, next-state logic and bit counter. The top level holds the holding register, shift register, parity latch and line mux.

## Test plan
- Reset, then 0xA5 with PAR_EN=0:
  - OUT sequence 0,1,0,1,0,0,1,0,1,1 over 10 cycles starting one edge after accept
  - BUSY high for 10 cycles; READY back high at the edge entering START
- 0xA5 with PAR_EN=1, PAR_TYP=0: 11-cycle frame with parity bit 0. Repeat with PAR_TYP=1: parity bit 1.
- 0x00 with odd parity: 8 zero data bits, parity bit 1, stop bit 1.
- Back-to-back 0x55 then 0x0F, the second accepted during the first frame's data bits:
  - 20 contiguous cycles with no idle gap; the second start bit directly follows the first stop bit
  - BUSY stays high throughout
- VALID high with READY low during a frame, P_DATA toggling: that byte is not captured. The byte accepted after READY rises is sent intact, and a PAR_TYP change after accept does not alter it.
- Reset asserted during data bit 3 with a byte also held:
  - OUT goes to 1 and BUSY to 0 immediately
  - after release, no frame is emitted until a new accept; READY is 1

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: Gray-coded controller states, parity constants and the default frame width.
// Both the transmit and receive controllers import this so their frame formats stay in lockstep.
package uart_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int MAX_DATA_WIDTH     = 16;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_START  = 3'b001,
    ST_DATA   = 3'b011,
    ST_PARITY = 3'b010,
    ST_STOP   = 3'b110
  } uart_state_e;

  // Data narrower than MAX_DATA_WIDTH is zero-extended, which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [MAX_DATA_WIDTH-1:0] data,
                                      input logic                      par_typ);
    return (^data) ^ (par_typ == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_fsm.sv
// Transmit frame sequencer: state register, next-state logic and data bit counter.
// state  | meaning: IDLE line high | START start bit | DATA data bits | PARITY parity bit | STOP stop bit
module uart_tx_fsm
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold_full,
  input  logic        par_en_q,
  output uart_state_e state,
  output uart_state_e state_nxt,
  output logic        load,
  output logic        busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic [CNT_W-1:0] bit_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
    end else if (load) begin
      bit_cnt <= '0;
    end else if (state == ST_DATA) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE:   state_nxt = hold_full ? ST_START : ST_IDLE;
      ST_START:  state_nxt = ST_DATA;
      ST_DATA: begin
        if (bit_cnt == LAST_BIT) begin
          state_nxt = par_en_q ? ST_PARITY : ST_STOP;
        end else begin
          state_nxt = ST_DATA;
        end
      end
      ST_PARITY: state_nxt = ST_STOP;
      ST_STOP:   state_nxt = hold_full ? ST_START : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // A load is exactly a transition into START; STOP->START gives gapless frames.
  always_comb begin
    load = 1'b0;
    busy = 1'b1;
    case (state)
      ST_IDLE: begin
        load = hold_full;
        busy = 1'b0;
      end
      ST_STOP: load = hold_full;
      default: begin
        load = 1'b0;
        busy = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding register feeding a shift register, with a registered line output.
// One bit per clock; frame is start, data LSB first, optional parity, one stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  UART_TX_CLK,
  input  logic                  UART_TX_RST,
  input  logic [DATA_WIDTH-1:0] UART_TX_P_DATA,
  input  logic                  UART_TX_DATA_VALID,
  input  logic                  UART_TX_PAR_EN,
  input  logic                  UART_TX_PAR_TYP,
  output logic                  UART_TX_READY,
  output logic                  UART_TX_OUT,
  output logic                  UART_TX_BUSY
);

  logic                  hold_full;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_par_en;
  logic                  hold_par_typ;

  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_nxt;
  logic                  par_bit_q;
  logic                  par_bit_nxt;
  logic                  par_en_q;
  logic                  line_q;
  logic                  line_nxt;

  logic                  accept;
  logic                  load;
  uart_state_e           state;
  uart_state_e           state_nxt;

  assign UART_TX_READY = ~hold_full & ~UART_TX_RST;
  assign accept        = UART_TX_DATA_VALID & UART_TX_READY;

  uart_tx_fsm #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fsm (
    .clk       (UART_TX_CLK),
    .rst       (UART_TX_RST),
    .hold_full (hold_full),
    .par_en_q  (par_en_q),
    .state     (state),
    .state_nxt (state_nxt),
    .load      (load),
    .busy      (UART_TX_BUSY)
  );

  // READY is low whenever hold_full is set, so accept and load never coincide.
  always_ff @(posedge UART_TX_CLK or posedge UART_TX_RST) begin
    if (UART_TX_RST) begin
      hold_full    <= 1'b0;
      hold_data    <= '0;
      hold_par_en  <= 1'b0;
      hold_par_typ <= PAR_EVEN;
    end else if (accept) begin
      hold_full    <= 1'b1;
      hold_data    <= UART_TX_P_DATA;
      hold_par_en  <= UART_TX_PAR_EN;
      hold_par_typ <= UART_TX_PAR_TYP;
    end else if (load) begin
      hold_full    <= 1'b0;
    end
  end

  always_comb begin
    shift_nxt = shift_q;
    if (load) begin
      shift_nxt = hold_data;
    end else if (state == ST_DATA) begin
      shift_nxt = shift_q >> 1;
    end
  end

  always_comb begin
    par_bit_nxt = par_bit_q;
    if (load) begin
      par_bit_nxt = parity_bit(MAX_DATA_WIDTH'(hold_data), hold_par_typ);
    end
  end

  always_ff @(posedge UART_TX_CLK or posedge UART_TX_RST) begin
    if (UART_TX_RST) begin
      shift_q   <= '0;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
    end else begin
      shift_q   <= shift_nxt;
      par_bit_q <= par_bit_nxt;
      if (load) begin
        par_en_q <= hold_par_en;
      end
    end
  end

  // Line is driven from the upcoming state so OUT is a flop with no decode glitches.
  always_comb begin
    line_nxt = 1'b1;
    case (state_nxt)
      ST_START:  line_nxt = 1'b0;
      ST_DATA:   line_nxt = shift_nxt[0];
      ST_PARITY: line_nxt = par_bit_nxt;
      default:   line_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge UART_TX_CLK or posedge UART_TX_RST) begin
    if (UART_TX_RST) begin
      line_q <= 1'b1;
    end else begin
      line_q <= line_nxt;
    end
  end

  assign UART_TX_OUT = line_q;

endmodule
